// File: rtl/apb_ic_pkg.sv
// Shared types and helpers for the APB interconnect arbiters.
//   arb_mode_e  : runtime arbitration mode (fixed / round-robin / weighted round-robin)
//   arb_state_e : arbiter FSM state
//   onehot2idx  : one-hot (up to 16 bits) to binary index
package apb_ic_pkg;

    typedef enum logic [1:0] {
        ARB_FIXED = 2'd0,
        ARB_RR    = 2'd1,
        ARB_WRR   = 2'd2
    } arb_mode_e;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

    localparam int ARB_MAX_MASTERS = 16;
    localparam int ARB_WAIT_W      = 8;

    // OR of the indices of the set bits; exact for a one-hot or all-zero input.
    function automatic logic [3:0] onehot2idx(input logic [ARB_MAX_MASTERS-1:0] oh);
        logic [3:0] idx;
        idx = '0;
        for (int i = 0; i < ARB_MAX_MASTERS; i++) begin
            if (oh[i]) idx = idx | 4'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/apb_rot_pick.sv
// Rotating priority picker (combinational).
//   i_req : request vector
//   i_ptr : index that has highest priority; priority falls with increasing index, wrapping
//   o_gnt : one-hot winner (0 when no request)
//   o_idx : winner index (0 when no request)
//   o_any : at least one request present
module apb_rot_pick
    import apb_ic_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_gnt,
    output logic [IW-1:0] o_idx,
    output logic          o_any
);

    logic          w_hit_hi;
    logic          w_hit_lo;
    logic [IW-1:0] w_idx_hi;
    logic [IW-1:0] w_idx_lo;

    // Two passes folded into one loop: lowest request at or above the pointer,
    // and lowest request below it. The first one wins, the second is the wrap.
    always_comb begin
        w_hit_hi = 1'b0;
        w_hit_lo = 1'b0;
        w_idx_hi = '0;
        w_idx_lo = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (i_req[j]) begin
                if (j >= int'(i_ptr)) begin
                    w_hit_hi = 1'b1;
                    w_idx_hi = IW'(j);
                end else begin
                    w_hit_lo = 1'b1;
                    w_idx_lo = IW'(j);
                end
            end
        end
        o_any = w_hit_hi | w_hit_lo;
        o_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
        o_gnt = o_any ? (N'(1) << o_idx) : '0;
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// N-master APB request arbiter, one per slave port. Holds a grant until the
// granted transfer completes; fixed (with starvation guard), RR and WRR modes.
//   I_PCLK / I_PRESET : clock, async active-high reset
//   I_ARB_MODE        : 0 fixed, 1 RR, 2 WRR, 3 as RR; taken only while idle
//   I_REQ             : level requests
//   I_WEIGHT          : WRR weights, master i at [i*W +: W], 0 acts as 1
//   I_XFER_DONE       : completion of the granted transfer
//   O_GNT / O_GNT_ID / O_GNT_VALID : registered grant, its index, any-grant
//
// state     | meaning
// ----------+---------------------------------------------------------
// ARB_IDLE  | no grant; arbitrates as soon as any request appears
// ARB_GRANT | one master owns the port until I_XFER_DONE
module apb_master_arbiter
    import apb_ic_pkg::*;
#(
    parameter int NO_OF_MASTERS   = 4,
    parameter int MASTER_ID_WIDTH = (NO_OF_MASTERS == 1) ? 1 : $clog2(NO_OF_MASTERS),
    parameter int WEIGHT_WIDTH    = 4,
    parameter int STARVE_LIMIT    = 16
) (
    input  logic                                  I_PCLK,
    input  logic                                  I_PRESET,
    input  logic [1:0]                            I_ARB_MODE,
    input  logic [NO_OF_MASTERS-1:0]              I_REQ,
    input  logic [NO_OF_MASTERS*WEIGHT_WIDTH-1:0] I_WEIGHT,
    input  logic                                  I_XFER_DONE,
    output logic [NO_OF_MASTERS-1:0]              O_GNT,
    output logic [MASTER_ID_WIDTH-1:0]            O_GNT_ID,
    output logic                                  O_GNT_VALID
);

    localparam int N  = NO_OF_MASTERS;
    localparam int IW = MASTER_ID_WIDTH;
    localparam int WW = WEIGHT_WIDTH;

    arb_state_e      r_state, w_state_nxt;
    arb_mode_e       r_mode, w_mode_in, w_mode;
    logic [N-1:0]    r_gnt, w_gnt_nxt;
    logic [IW-1:0]   r_gnt_id, w_gnt_id_nxt;
    logic [IW-1:0]   r_ptr, w_ptr_nxt;
    logic [ARB_WAIT_W-1:0] r_wait [N];
    // Credits are kept as "transfers used since reload"; credit = weight - used.
    // This makes reset and reload a plain clear instead of a load from I_WEIGHT.
    logic [WW-1:0]   r_used [N];
    logic [WW-1:0]   w_used_dec [N];
    logic [WW-1:0]   w_weff [N];
    logic [N-1:0]    w_credit_after, w_starved;
    logic            w_done, w_arb, w_reload;
    logic [IW-1:0]   w_owner, w_wrr_ptr;
    logic [N-1:0]    w_pick_req, w_win;
    logic [IW-1:0]   w_pick_ptr, w_win_idx;
    logic            w_win_any;

    function automatic logic [IW-1:0] ptr_next(input logic [IW-1:0] m);
        return (m == IW'(N - 1)) ? '0 : m + IW'(1);
    endfunction

    always_comb begin
        case (I_ARB_MODE)
            2'd0:    w_mode_in = ARB_FIXED;
            2'd2:    w_mode_in = ARB_WRR;
            default: w_mode_in = ARB_RR;
        endcase
    end

    assign w_mode  = (r_state == ARB_IDLE) ? w_mode_in : r_mode;
    assign w_done  = (r_state == ARB_GRANT) && I_XFER_DONE;
    assign w_owner = IW'(onehot2idx(ARB_MAX_MASTERS'(r_gnt)));

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_weff[i] = (I_WEIGHT[i*WW +: WW] == '0) ? WW'(1) : I_WEIGHT[i*WW +: WW];
            w_used_dec[i] = r_used[i];
            if (w_done && (w_mode == ARB_WRR) && (w_owner == IW'(i)) && (r_used[i] < w_weff[i]))
                w_used_dec[i] = r_used[i] + WW'(1);
            w_credit_after[i] = (w_used_dec[i] < w_weff[i]);
            w_starved[i] = (STARVE_LIMIT != 0) && I_REQ[i] &&
                           (r_wait[i] == ARB_WAIT_W'(STARVE_LIMIT));
        end
    end

    // WRR: the owner keeps the pointer while it still has credit and still asks.
    assign w_wrr_ptr = (w_credit_after[w_owner] && I_REQ[w_owner]) ? w_owner : ptr_next(w_owner);
    assign w_reload  = (w_mode == ARB_WRR) && ((r_state == ARB_IDLE) || w_done) &&
                       (|I_REQ) && ~|(I_REQ & w_credit_after);

    always_comb begin
        w_pick_req = I_REQ;
        w_pick_ptr = r_ptr;
        case (w_mode)
            ARB_FIXED: begin
                w_pick_ptr = '0;
                if (|w_starved) w_pick_req = w_starved;
            end
            ARB_WRR: begin
                if (w_done) w_pick_ptr = w_wrr_ptr;
                w_pick_req = w_reload ? I_REQ : (I_REQ & w_credit_after);
            end
            default: ;
        endcase
    end

    apb_rot_pick #(.N(N), .IW(IW)) u_pick (
        .i_req (w_pick_req),
        .i_ptr (w_pick_ptr),
        .o_gnt (w_win),
        .o_idx (w_win_idx),
        .o_any (w_win_any)
    );

    assign w_arb = ((r_state == ARB_IDLE) || w_done) && w_win_any;

    always_comb begin
        w_state_nxt  = r_state;
        w_gnt_nxt    = r_gnt;
        w_gnt_id_nxt = r_gnt_id;
        w_ptr_nxt    = r_ptr;
        if (w_done) begin
            w_state_nxt  = ARB_IDLE;
            w_gnt_nxt    = '0;
            w_gnt_id_nxt = '0;
            if (w_mode == ARB_WRR) w_ptr_nxt = w_wrr_ptr;
        end
        if (w_arb) begin
            w_state_nxt  = ARB_GRANT;
            w_gnt_nxt    = w_win;
            w_gnt_id_nxt = w_win_idx;
            if (w_mode == ARB_RR)       w_ptr_nxt = ptr_next(w_win_idx);
            else if (w_mode == ARB_WRR) w_ptr_nxt = w_win_idx;
        end
    end

    always_ff @(posedge I_PCLK or posedge I_PRESET) begin
        if (I_PRESET) begin
            r_state  <= ARB_IDLE;
            r_mode   <= ARB_FIXED;
            r_gnt    <= '0;
            r_gnt_id <= '0;
            r_ptr    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_gnt_id <= w_gnt_id_nxt;
            r_ptr    <= w_ptr_nxt;
            if (r_state == ARB_IDLE) r_mode <= w_mode_in;
        end
    end

    always_ff @(posedge I_PCLK or posedge I_PRESET) begin
        if (I_PRESET) begin
            for (int i = 0; i < N; i++) begin
                r_wait[i] <= '0;
                r_used[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                r_used[i] <= w_reload ? '0 : w_used_dec[i];
                if (!I_REQ[i] || r_gnt[i] || (w_arb && w_win[i]))
                    r_wait[i] <= '0;
                else if (r_wait[i] != ARB_WAIT_W'(STARVE_LIMIT))
                    r_wait[i] <= r_wait[i] + 1'b1;
            end
        end
    end

    assign O_GNT       = r_gnt;
    assign O_GNT_ID    = r_gnt_id;
    assign O_GNT_VALID = |r_gnt;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed vector table, hand sequences for
// grant-hold and mid-transfer reset, then random traffic against a reference model.
module tb_apb_master_arbiter;

    localparam int NM     = 4;
    localparam int STARVE = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic        done;
    logic [1:0]  mode;
    logic [15:0] weight;
    logic [3:0]  gnt;
    logic [1:0]  gnt_id;
    logic        gnt_valid;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_owner;
    int m_ptr;
    int m_mode;
    int m_credit [NM];
    int m_wait [NM];

    typedef struct {
        bit         pre_rst;
        logic [3:0] req;
        logic       done;
        logic [1:0] mode;
        logic [3:0] exp_gnt;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    apb_master_arbiter #(
        .NO_OF_MASTERS (NM),
        .WEIGHT_WIDTH  (4),
        .STARVE_LIMIT  (STARVE)
    ) dut (
        .I_PCLK      (clk),
        .I_PRESET    (rst),
        .I_ARB_MODE  (mode),
        .I_REQ       (req),
        .I_WEIGHT    (weight),
        .I_XFER_DONE (done),
        .O_GNT       (gnt),
        .O_GNT_ID    (gnt_id),
        .O_GNT_VALID (gnt_valid)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
        end
    endtask

    function automatic int eff_w(int i);
        int w;
        w = int'(weight[i*4 +: 4]);
        return (w == 0) ? 1 : w;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_ptr   = 0;
        m_mode  = 0;
        for (int i = 0; i < NM; i++) begin
            m_credit[i] = eff_w(i);
            m_wait[i]   = 0;
        end
    endtask

    // One clock edge of the arbiter's rules, using the inputs currently driven.
    task automatic model_step();
        int md, old, win, st, idx;
        bit arb;
        old = m_owner;
        md  = (old < 0) ? int'(mode) : m_mode;
        if (md == 3) md = 1;
        arb = 0;
        win = -1;
        if (old >= 0 && done) begin
            if (md == 2) begin
                if (m_credit[old] > 0) m_credit[old]--;
                m_ptr = (m_credit[old] > 0 && req[old]) ? old : (old + 1) % NM;
            end
            arb = (req != 0);
            if (!arb) m_owner = -1;
        end else if (old < 0 && req != 0) begin
            arb = 1;
        end
        if (arb) begin
            if (md == 0) begin
                st = -1;
                for (int i = NM - 1; i >= 0; i--) begin
                    if (req[i]) win = i;
                    if (req[i] && m_wait[i] == STARVE) st = i;
                end
                if (st >= 0) win = st;
            end else if (md == 1) begin
                for (int k = NM - 1; k >= 0; k--) begin
                    idx = (m_ptr + k) % NM;
                    if (req[idx]) win = idx;
                end
                m_ptr = (win + 1) % NM;
            end else begin
                for (int k = NM - 1; k >= 0; k--) begin
                    idx = (m_ptr + k) % NM;
                    if (req[idx] && m_credit[idx] > 0) win = idx;
                end
                if (win < 0) begin
                    for (int i = 0; i < NM; i++) m_credit[i] = eff_w(i);
                    for (int k = NM - 1; k >= 0; k--) begin
                        idx = (m_ptr + k) % NM;
                        if (req[idx]) win = idx;
                    end
                end
                m_ptr = win;
            end
            m_owner = win;
        end
        for (int i = 0; i < NM; i++) begin
            if (!req[i] || i == old || i == win) m_wait[i] = 0;
            else if (m_wait[i] < STARVE) m_wait[i]++;
        end
        if (old < 0) m_mode = int'(mode);
    endtask

    task automatic step(input string nm);
        int eg;
        model_step();
        @(posedge clk);
        #1;
        eg = (m_owner >= 0) ? (1 << m_owner) : 0;
        chk({nm, ".gnt"}, 32'(gnt), eg);
        if (m_owner >= 0) chk({nm, ".id"}, 32'(gnt_id), m_owner);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = 1'b0;
        #2;
        chk("reset.gnt", 32'(gnt), 0);
        chk("reset.id", 32'(gnt_id), 0);
        chk("reset.valid", 32'(gnt_valid), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        checks++;
        if (!$onehot0(gnt) || (gnt_valid !== (|gnt)) || ((gnt != 0) && (gnt !== (4'b1 << gnt_id)))) begin
            errors++;
            $display("FAIL invariant gnt=%b id=%0d valid=%b", gnt, gnt_id, gnt_valid);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        rst    = 1'b0;
        req    = '0;
        done   = 1'b0;
        mode   = 2'd0;
        weight = {4'd0, 4'd1, 4'd1, 4'd3};

        // round-robin sweep, then idle-state done pulses
        tbl.push_back('{1'b1, 4'hF, 1'b0, 2'd1, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd1, 4'b0010});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd1, 4'b0100});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd1, 4'b1000});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd1, 4'b0001});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 2'd1, 4'b0000});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 2'd1, 4'b0000});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 2'd1, 4'b0000});
        tbl.push_back('{1'b0, 4'h4, 1'b0, 2'd1, 4'b0100});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 2'd1, 4'b0000});
        // fixed priority with starvation guard at 4
        tbl.push_back('{1'b1, 4'h3, 1'b0, 2'd0, 4'b0001});
        tbl.push_back('{1'b0, 4'h3, 1'b1, 2'd0, 4'b0001});
        tbl.push_back('{1'b0, 4'h3, 1'b1, 2'd0, 4'b0001});
        tbl.push_back('{1'b0, 4'h3, 1'b1, 2'd0, 4'b0001});
        tbl.push_back('{1'b0, 4'h3, 1'b1, 2'd0, 4'b0010});
        tbl.push_back('{1'b0, 4'h3, 1'b1, 2'd0, 4'b0001});
        tbl.push_back('{1'b0, 4'h3, 1'b1, 2'd0, 4'b0001});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 2'd0, 4'b0000});
        // weighted round-robin, weights 3,1,1,0
        tbl.push_back('{1'b1, 4'hF, 1'b0, 2'd2, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0010});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0100});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b1000});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0001});
        tbl.push_back('{1'b0, 4'hF, 1'b1, 2'd2, 4'b0010});
        tbl.push_back('{1'b0, 4'h0, 1'b1, 2'd2, 4'b0000});

        #1;
        do_reset();

        foreach (tbl[k]) begin
            if (tbl[k].pre_rst) do_reset();
            req  = tbl[k].req;
            done = tbl[k].done;
            mode = tbl[k].mode;
            step($sformatf("tbl%0d", k));
            chk($sformatf("tbl%0d.exp", k), 32'(gnt), 32'(tbl[k].exp_gnt));
        end
        done = 1'b0;

        // grant held while requests change and no completion arrives
        do_reset();
        mode = 2'd1;
        req  = 4'b0100;
        step("hold.start");
        chk("hold.first", 32'(gnt), 32'(4'b0100));
        req = 4'b0001;
        for (int c = 0; c < 5; c++) begin
            step("hold");
            chk($sformatf("hold%0d.gnt", c), 32'(gnt), 32'(4'b0100));
            chk($sformatf("hold%0d.id", c), 32'(gnt_id), 2);
        end
        done = 1'b1;
        step("hold.done");
        chk("hold.next", 32'(gnt), 32'(4'b0001));
        req = 4'b0000;
        step("hold.idle");
        done = 1'b0;

        // reset between edges while master 1 holds the grant
        do_reset();
        mode = 2'd1;
        req  = 4'b0010;
        step("mrst.start");
        chk("mrst.before", 32'(gnt), 32'(4'b0010));
        #2;
        rst = 1'b1;
        #1;
        chk("mrst.gnt", 32'(gnt), 0);
        chk("mrst.valid", 32'(gnt_valid), 0);
        chk("mrst.id", 32'(gnt_id), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        req  = 4'b1000;
        done = 1'b0;
        step("mrst.after");
        chk("mrst.after.gnt", 32'(gnt), 32'(4'b1000));
        chk("mrst.after.id", 32'(gnt_id), 3);

        // random traffic
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            if (n == 1500) do_reset();
            mode = 2'($urandom_range(3, 0));
            for (int b = 0; b < NM; b++) begin
                if ($urandom_range(7, 0) == 0) req[b] = ~req[b];
            end
            done = ($urandom_range(2, 0) == 0);
            step("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
